// File: rtl/rv_mem_arb.sv
// Round-robin arbiter that shares one fixed-latency memory port between
// an instruction-fetch requester and a data load/store requester.
module rv_mem_arb #(
  parameter int DPWIDTH = 32,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ireq,
  input  logic [DPWIDTH-1:0] iaddr,
  output logic               iack,
  output logic [DPWIDTH-1:0] irdata,
  input  logic               dreq,
  input  logic               dwe,
  input  logic [DPWIDTH-1:0] daddr,
  input  logic [DPWIDTH-1:0] dwdata,
  output logic               dack,
  output logic [DPWIDTH-1:0] drdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DPWIDTH-1:0] mem_addr,
  output logic [DPWIDTH-1:0] mem_wdata,
  input  logic [DPWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t             state, state_nxt;
  logic [2:0]         cnt, cnt_nxt;
  logic               gnt_data, gnt_data_nxt;
  logic               last_grant, last_grant_nxt;
  logic               we_q, we_nxt;
  logic               pick_data;
  logic [DPWIDTH-1:0] addr_nxt, wdata_nxt;
  logic [DPWIDTH-1:0] irdata_nxt, drdata_nxt;

  // last_grant resets to data (1) so the first contended grant goes to fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt_data   <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      irdata     <= '0;
      drdata     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      gnt_data   <= gnt_data_nxt;
      last_grant <= last_grant_nxt;
      we_q       <= we_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      irdata     <= irdata_nxt;
      drdata     <= drdata_nxt;
    end
  end

  assign pick_data = dreq && (!ireq || !last_grant);

  // WAIT spans MEM_LAT cycles: the counter runs MEM_LAT-1 down to 0 and
  // the cycle at count 0 is the one in which mem_rdata is valid
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    gnt_data_nxt   = gnt_data;
    last_grant_nxt = last_grant;
    we_nxt         = we_q;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    irdata_nxt     = irdata;
    drdata_nxt     = drdata;
    case (state)
      IDLE: begin
        if (ireq || dreq) begin
          gnt_data_nxt   = pick_data;
          last_grant_nxt = pick_data;
          we_nxt         = pick_data && dwe;
          addr_nxt       = pick_data ? daddr : iaddr;
          wdata_nxt      = pick_data ? dwdata : '0;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = LAT_M1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          if (gnt_data) begin
            drdata_nxt = we_q ? '0 : mem_rdata;
          end else begin
            irdata_nxt = mem_rdata;
          end
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign mem_en = (state == ISSUE);
  assign mem_we = (state == ISSUE) && we_q;
  assign iack   = (state == RESP) && !gnt_data;
  assign dack   = (state == RESP) && gnt_data;

endmodule
